// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and RV64 funct3 values.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_XFER = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_e;

    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_SD      = 3'b011;
    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of a little-endian load of 1, 2, 4 or 8 bytes to 64 bits.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [63:0] data,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [63:0] result
);

    logic signed [63:0] sext;
    logic        [63:0] zext;

    always_comb begin
        sext = '0;
        zext = '0;
        unique case (size)
            SZ_B: begin
                sext = 64'(signed'(data[7:0]));
                zext = 64'(data[7:0]);
            end
            SZ_H: begin
                sext = 64'(signed'(data[15:0]));
                zext = 64'(data[15:0]);
            end
            SZ_W: begin
                sext = 64'(signed'(data[31:0]));
                zext = 64'(data[31:0]);
            end
            SZ_D: begin
                sext = signed'(data);
                zext = data;
            end
        endcase
        result = is_unsigned ? zext : sext;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serializes one load or store into little-endian byte accesses on an
// 8-bit data memory, rejecting misaligned, out-of-range and illegal requests up front.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        state, state_nxt;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [63:0]       wdata;
    logic [63:0]       rdata;
    logic              write;
    logic [2:0]        funct3;
    logic              err;

    logic [3:0]        req_n;
    logic [ADDR_W:0]   req_end;
    logic              req_err;
    logic [2:0]        last_cnt;
    logic              xfer_on;
    logic              resp_on;
    logic [63:0]       ext_data;

    // The end address gets one extra bit so addresses near the top of the space cannot wrap.
    assign req_n    = size_bytes(req_funct3[1:0]);
    assign req_end  = {1'b0, req_addr} + (ADDR_W+1)'(req_n);
    assign req_err  = ((req_addr[3:0] & (req_n - 4'd1)) != 4'd0)
                    || (req_end > (ADDR_W+1)'(MEM_DEPTH))
                    || (!req_write && req_funct3 == F3_ILLEGAL);
    assign last_cnt = 3'(size_bytes(funct3[1:0]) - 4'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= LSU_IDLE;
            cnt    <= '0;
            base   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            write  <= 1'b0;
            funct3 <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        base   <= req_addr;
                        wdata  <= req_wdata;
                        write  <= req_write;
                        funct3 <= req_funct3;
                        err    <= req_err;
                        cnt    <= '0;
                        rdata  <= '0;
                    end
                end
                LSU_XFER: begin
                    if (!write) begin
                        rdata[{cnt, 3'b000} +: 8] <= mem_rdata;
                    end
                    cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LSU_IDLE: if (req_valid) state_nxt = req_err ? LSU_RESP : LSU_XFER;
            LSU_XFER: if (cnt == last_cnt) state_nxt = LSU_RESP;
            LSU_RESP: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    load_extend u_load_extend (
        .data        (rdata),
        .size        (lsu_size_e'(funct3[1:0])),
        .is_unsigned (funct3[2]),
        .result      (ext_data)
    );

    // Outputs are gated by reset so that a reset landing mid-transfer never strobes memory.
    assign xfer_on    = reset && (state == LSU_XFER);
    assign resp_on    = reset && (state == LSU_RESP);
    assign req_ready  = !reset || (state == LSU_IDLE);
    assign busy       = reset && (state != LSU_IDLE);
    assign resp_valid = resp_on;
    assign resp_err   = resp_on && err;
    assign resp_rdata = (resp_on && !err && !write) ? ext_data : 64'd0;
    assign mem_addr   = xfer_on ? base + ADDR_W'(cnt) : '0;
    assign mem_wdata  = (xfer_on && write) ? wdata[{cnt, 3'b000} +: 8] : 8'd0;
    assign mem_we     = xfer_on && write;
    assign mem_re     = xfer_on && !write;

endmodule
